stall_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/md_busy_ctr.sv | 40 ++++
 rtl/stall_ctrl.sv | 101 ++++++++++
 tb/tb_stall_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and helpers for the D-stage hazard scheduler.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // One in-flight register write: destination and cycles until forwardable.
  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
  } sb_entry_t;

  // Saturating decrement: a result that is already forwardable stays forwardable.
  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div occupancy counter: loads the op latency on issue, counts down to idle.
module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: issue reloads, otherwise drain toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_i) begin
      cnt_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Busy comes straight from the register, so it rises the cycle after issue.
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// D-stage hazard scheduler: E/M/W write scoreboard, Tuse/Tnew stall compare,
// rs/rt forwarding selects and mult/div busy interlock.
module stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] Tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
);

  sb_entry_t e_q, m_q, w_q;
  sb_entry_t e_d, m_d, w_d;

  // Any in-flight producer of op that will not be ready by the time D needs it.
  function automatic logic op_stall(input logic [4:0] op, input logic [1:0] tuse,
                                    input sb_entry_t e, input sb_entry_t m,
                                    input sb_entry_t w);
    logic hit;
    hit = 1'b0;
    if (tuse != TUSE_NONE && op != 5'd0) begin
      if (e.addr == op && e.tnew > tuse) hit = 1'b1;
      if (m.addr == op && m.tnew > tuse) hit = 1'b1;
      if (w.addr == op && w.tnew > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  // Only the youngest matching producer may forward; an older stage holds stale data.
  function automatic logic [1:0] op_fwd(input logic [4:0] op, input sb_entry_t e,
                                        input sb_entry_t m, input sb_entry_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (op != 5'd0) begin
      if (e.addr == op)      sel = (e.tnew == 2'd0) ? FWD_E : FWD_RF;
      else if (m.addr == op) sel = (m.tnew == 2'd0) ? FWD_M : FWD_RF;
      else if (w.addr == op) sel = (w.tnew == 2'd0) ? FWD_W : FWD_RF;
    end
    return sel;
  endfunction

  // Stall and forwarding decode, held quiet while in reset.
  always_comb begin
    stall  = 1'b0;
    fwd_rs = FWD_RF;
    fwd_rt = FWD_RF;
    if (!reset) begin
      stall  = op_stall(rs_D, Tuse_rs_D, e_q, m_q, w_q)
             | op_stall(rt_D, Tuse_rt_D, e_q, m_q, w_q)
             | (md_use_D & md_busy);
      fwd_rs = op_fwd(rs_D, e_q, m_q, w_q);
      fwd_rt = op_fwd(rt_D, e_q, m_q, w_q);
    end
  end

  // Scoreboard advance: M and W always move, E takes a bubble on stall.
  always_comb begin
    w_d = {m_q.addr, sat_dec(m_q.tnew)};
    m_d = {e_q.addr, sat_dec(e_q.tnew)};
    e_d = stall ? sb_entry_t'('0) : {wa_D, Tnew_D};
  end

  // Scoreboard registers, cleared in one edge on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .issue_i (md_start_D & ~stall),
    .is_div_i(md_div_D),
    .busy_o  (md_busy)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed pipeline scenarios followed by
// random D-stage traffic, all checked against a timestamp-based reference model.
module tb_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each in-flight write remembers the absolute cycle at which
  // its value becomes forwardable; index 0 is the youngest (E), 2 the oldest (W).
  int cyc = 0;
  int waddr[3];
  int wready[3];
  int md_end = -1;

  always #5 clk = ~clk;

  stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .Tuse_rs_D (Tuse_rs_D),
    .Tuse_rt_D (Tuse_rt_D),
    .wa_D      (wa_D),
    .Tnew_D    (Tnew_D),
    .md_start_D(md_start_D),
    .md_div_D  (md_div_D),
    .md_use_D  (md_use_D),
    .stall     (stall),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt),
    .md_busy   (md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_wait(input int i);
    int t;
    t = wready[i] - cyc;
    return (t > 0) ? t : 0;
  endfunction

  function automatic bit m_op_stall(input int op, input int tuse);
    bit hit;
    hit = 1'b0;
    if (op != 0 && tuse != 3)
      for (int i = 0; i < 3; i++)
        if (waddr[i] == op && m_wait(i) > tuse) hit = 1'b1;
    return hit;
  endfunction

  function automatic int m_fwd(input int op);
    if (reset || op == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (waddr[i] == op) return (m_wait(i) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_busy();
    return cyc <= md_end;
  endfunction

  function automatic bit m_stall();
    if (reset) return 1'b0;
    return m_op_stall(int'(rs_D), int'(Tuse_rs_D)) | m_op_stall(int'(rt_D), int'(Tuse_rt_D))
         | (md_use_D & m_busy());
  endfunction

  task automatic model_step(input bit st);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        waddr[i]  = 0;
        wready[i] = 0;
      end
      md_end = -1;
    end else begin
      waddr[2] = waddr[1]; wready[2] = wready[1];
      waddr[1] = waddr[0]; wready[1] = wready[0];
      if (st) begin
        waddr[0]  = 0;
        wready[0] = 0;
      end else begin
        waddr[0]  = int'(wa_D);
        wready[0] = cyc + 1 + int'(Tnew_D);
        if (md_start_D) md_end = cyc + (md_div_D ? DIV_N : MULT_N);
      end
    end
    cyc++;
  endtask

  // One D-stage cycle: check outputs mid-cycle against the model (and optional
  // literal expectations), then clock the edge and advance the model.
  task automatic cycle(input string tag, input int ls = -1, input int lfr = -1,
                       input int lft = -1, input int lb = -1);
    bit es;
    @(negedge clk);
    es = m_stall();
    chk({tag, ".stall"}, stall, es);
    chk({tag, ".fwd_rs"}, fwd_rs, m_fwd(int'(rs_D)));
    chk({tag, ".fwd_rt"}, fwd_rt, m_fwd(int'(rt_D)));
    chk({tag, ".md_busy"}, md_busy, m_busy());
    if (ls  >= 0) chk({tag, ".stall_lit"}, stall, ls);
    if (lfr >= 0) chk({tag, ".fwd_rs_lit"}, fwd_rs, lfr);
    if (lft >= 0) chk({tag, ".fwd_rt_lit"}, fwd_rt, lft);
    if (lb  >= 0) chk({tag, ".md_busy_lit"}, md_busy, lb);
    @(posedge clk);
    model_step(es);
    #1;
  endtask

  task automatic drive(input int rs, input int tus, input int rt, input int tut,
                       input int wa, input int tn, input bit ms = 0, input bit md = 0,
                       input bit mu = 0);
    rs_D = 5'(rs); Tuse_rs_D = 2'(tus);
    rt_D = 5'(rt); Tuse_rt_D = 2'(tut);
    wa_D = 5'(wa); Tnew_D = 2'(tn);
    md_start_D = ms; md_div_D = md; md_use_D = mu;
  endtask

  task automatic nops(input int n);
    drive(0, 3, 0, 3, 0, 0);
    for (int i = 0; i < n; i++) cycle("nop");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      waddr[i]  = 0;
      wready[i] = 0;
    end
    reset = 1'b1;
    drive(0, 3, 0, 3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cycle("reset", 0, 0, 0, 0);
    reset = 1'b0;
    nops(2);

    // Load-use: lw $8 then addu reading $8 at Tuse 1.
    drive(0, 3, 0, 3, 8, 2);
    cycle("lw", 0);
    drive(8, 1, 0, 3, 10, 1);
    cycle("ld_use1", 1);
    cycle("ld_use2", 0);
    nops(3);

    // Branch after ALU: addu $9 then beq on $9 at Tuse 0.
    drive(0, 3, 0, 3, 9, 1);
    cycle("addu9", 0);
    drive(9, 0, 0, 3, 0, 0);
    cycle("beq1", 1);
    cycle("beq2", 0, 2);
    nops(3);

    // Back-to-back ALU: ori $5, addu reading rt=$5, then another reader of $5.
    drive(0, 3, 0, 3, 5, 1);
    cycle("ori5", 0);
    drive(0, 3, 5, 1, 11, 1);
    cycle("addu_rt5", 0);
    drive(0, 3, 5, 1, 0, 0);
    cycle("next_rt5", 0, -1, 2);
    nops(3);

    // $0 write and read never interlock or forward.
    drive(0, 3, 0, 3, 0, 2);
    cycle("wa0", 0);
    drive(0, 0, 0, 3, 0, 0);
    cycle("rs0", 0, 0);
    nops(3);

    // Unused operand ignores a pending load.
    drive(0, 3, 0, 3, 12, 2);
    cycle("lw12", 0);
    drive(12, 3, 0, 3, 0, 0);
    cycle("rs_unused", 0, 0);
    nops(3);

    // div then mflo: busy 10 cycles starting the cycle after issue.
    drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
    cycle("div", 0, -1, -1, 0);
    drive(0, 3, 0, 3, 13, 1, 0, 0, 1);
    for (int i = 0; i < DIV_N + 2; i++)
      cycle("mflo", (i < DIV_N) ? 1 : 0, -1, -1, (i < DIV_N) ? 1 : 0);
    nops(3);

    // Reset mid-flight: div counting, lw in E, dependent addu stalled.
    drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
    cycle("div2", 0);
    nops(2);
    drive(0, 3, 0, 3, 8, 2);
    cycle("lw8");
    drive(8, 0, 0, 3, 14, 1);
    @(negedge clk);
    chk("pre_rst.stall", stall, 1);
    chk("pre_rst.md_busy", md_busy, m_busy());
    reset = 1'b1;
    #1;
    chk("in_rst.stall", stall, 0);
    chk("in_rst.fwd_rs", fwd_rs, 0);
    @(posedge clk);
    model_step(1'b0);
    #1;
    reset = 1'b0;
    cycle("post_rst", 0, 0, 0, 0);
    nops(2);

    // Random traffic over a small register set so matches are frequent.
    for (int n = 0; n < 600; n++) begin
      bit ms;
      ms = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            ms, $urandom_range(0, 1), ms | ($urandom_range(0, 5) == 0));
      reset = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
